// File: rtl/game_pkg.sv
// Shared types and constants for the whack-a-box round engine.
// FSM state encoding, level width and streak parameters.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2,
        OVER = 2'd3
    } game_state_t;

    localparam int LEVEL_W    = 3;
    localparam int STREAK_W   = 4;
    localparam int STREAK_LEN = 5;

endpackage

// File: rtl/game_tick_gen.sv
// Game-second prescaler: counts 0..TICKS-1 while enabled.
// sec_tick pulses for one cycle on the wrapping count.
module game_tick_gen #(
    parameter int TICKS = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic sec_tick
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign sec_tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/game_round_engine.sv
// Whack-a-box round controller: target pick, hit judging, timed levels.
// Optional STREAK_BONUS_EN adds a streak port and a bonus on every 5th hit.
module game_round_engine
    import game_pkg::*;
#(
    parameter int NUM_BOXES      = 8,
    parameter int BOX_W          = 3,
    parameter int SCORE_W        = 11,
    parameter int TICKS_PER_SEC  = 50_000_000,
    parameter int GAME_SECONDS   = 60,
    parameter int LEVEL_STEP_SEC = 20,
    parameter int NUM_LEVELS     = 3,
    parameter int WINDOW_TICKS   = 75_000_000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start_game,
    input  logic [BOX_W-1:0]   rand_in,
    input  logic               hit_valid,
    input  logic [BOX_W-1:0]   hit_box,
    output logic [BOX_W-1:0]   target_box,
    output logic               target_valid,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         time_left,
    output logic [2:0]         level,
    output logic               game_over,
    output logic               hit_flag,
    output logic               miss_flag
`ifdef STREAK_BONUS_EN
    ,
    output logic [3:0]         streak
`endif
);

    localparam int WIN_W = $clog2(WINDOW_TICKS + 1);
    localparam int SUM_W = SCORE_W + 5;
    localparam logic [BOX_W-1:0] NB = BOX_W'(NUM_BOXES);
    localparam logic [BOX_W-1:0] NB_LAST = BOX_W'(NUM_BOXES - 1);
    localparam logic [WIN_W-1:0] WIN_BASE = WIN_W'(WINDOW_TICKS);

    game_state_t state, state_nx;

    logic               sec_tick;
    logic               start_ok;
    logic               last_sec;
    logic               in_wait;
    logic               judged_hit;
    logic               judged_miss;
    logic [7:0]         lvl_sec;
    logic [WIN_W-1:0]   win;
    logic [WIN_W-1:0]   win_load;
    logic [BOX_W-1:0]   t_pick;
    logic [LEVEL_W:0]   gain;
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] score_hit;
    logic [SCORE_W-1:0] score_miss;
    logic               bonus;

    assign start_ok = start_game && (state == IDLE || state == OVER);
    assign last_sec = sec_tick && (time_left == 8'd1);
    assign in_wait  = (state == WAIT);
    assign judged_hit  = in_wait && hit_valid && (hit_box == target_box);
    assign judged_miss = in_wait && ((hit_valid && hit_box != target_box)
                                     || (!hit_valid && win <= WIN_W'(1)));

    game_tick_gen #(
        .TICKS (TICKS_PER_SEC)
    ) u_tick (
        .clk      (CLOCK_50),
        .reset    (reset),
        .en       (state == ARM || state == WAIT),
        .clr      (start_ok),
        .sec_tick (sec_tick)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_game) state_nx = ARM;
            ARM:     state_nx = WAIT;
            WAIT:    if (judged_hit || judged_miss) state_nx = ARM;
            OVER:    if (start_game) state_nx = ARM;
            default: state_nx = IDLE;
        endcase
        // The final second ends the round even if a hit was judged this edge
        if (last_sec)
            state_nx = OVER;
    end

    always_comb begin
        target_valid = (state == WAIT);
        game_over    = (state == OVER);
    end

    // Fold into range once, then step past the previous target
    always_comb begin
        t_pick = rand_in;
        if (rand_in >= NB)
            t_pick = rand_in - NB;
        if (t_pick == target_box)
            t_pick = (t_pick == NB_LAST) ? '0 : t_pick + 1'b1;
    end

    assign win_load = WIN_BASE >> (level - 3'd1);

`ifdef STREAK_BONUS_EN
    logic [2:0] run5;

    assign bonus = judged_hit && (run5 == 3'(STREAK_LEN - 1));

    always_ff @(posedge CLOCK_50) begin
        if (reset || start_ok || judged_miss) begin
            streak <= '0;
            run5   <= '0;
        end else if (judged_hit) begin
            streak <= (streak == 4'hf) ? streak : streak + 1'b1;
            run5   <= bonus ? '0 : run5 + 1'b1;
        end
    end
`else
    assign bonus = 1'b0;
`endif

    always_comb begin
        gain = bonus ? {level, 1'b0} : {1'b0, level};
        sum  = SUM_W'(score) + SUM_W'(gain);
        score_hit  = (sum > SUM_W'({SCORE_W{1'b1}})) ? '1 : sum[SCORE_W-1:0];
        score_miss = (score == '0) ? '0 : score - 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            target_box <= '0;
            score      <= '0;
            time_left  <= 8'(GAME_SECONDS);
            level      <= 3'd1;
            lvl_sec    <= '0;
            win        <= '0;
            hit_flag   <= 1'b0;
            miss_flag  <= 1'b0;
        end else begin
            hit_flag  <= judged_hit;
            miss_flag <= judged_miss;
            if (start_ok) begin
                score     <= '0;
                time_left <= 8'(GAME_SECONDS);
                level     <= 3'd1;
                lvl_sec   <= '0;
            end else begin
                if (sec_tick) begin
                    time_left <= time_left - 8'd1;
                    if (lvl_sec == 8'(LEVEL_STEP_SEC - 1)) begin
                        lvl_sec <= '0;
                        if (level < 3'(NUM_LEVELS))
                            level <= level + 3'd1;
                    end else begin
                        lvl_sec <= lvl_sec + 8'd1;
                    end
                end
                unique case (1'b1)
                    judged_hit:  score <= score_hit;
                    judged_miss: score <= score_miss;
                    default:     ;
                endcase
            end
            if (state == ARM) begin
                target_box <= t_pick;
                win        <= win_load;
            end else if (in_wait && win != '0) begin
                win <= win - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_game_round_engine.sv
// Bench for game_round_engine: directed vector table, then random
// stimulus against a cycle-count based reference model.
module tb_game_round_engine;

    localparam int NB   = 6;
    localparam int TPS  = 4;
    localparam int GS   = 6;
    localparam int STEP = 2;
    localparam int NL   = 3;
    localparam int WT   = 8;
    localparam int SMAX   = 2047;
    localparam int SMAX_S = 7;

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_WAIT = 2;
    localparam int P_OVER = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_game = 1'b0;
    logic [2:0]  rand_in = '0;
    logic        hit_valid = 1'b0;
    logic [2:0]  hit_box = '0;

    logic [2:0]  target_box, target_box_s;
    logic        target_valid, target_valid_s;
    logic [10:0] score;
    logic [2:0]  score_s;
    logic [7:0]  time_left, time_left_s;
    logic [2:0]  level, level_s;
    logic        game_over, game_over_s;
    logic        hit_flag, hit_flag_s;
    logic        miss_flag, miss_flag_s;
`ifdef STREAK_BONUS_EN
    logic [3:0]  streak, streak_s;
`endif

    always #5 clk = ~clk;

    game_round_engine #(
        .NUM_BOXES(NB), .BOX_W(3), .SCORE_W(11), .TICKS_PER_SEC(TPS),
        .GAME_SECONDS(GS), .LEVEL_STEP_SEC(STEP), .NUM_LEVELS(NL),
        .WINDOW_TICKS(WT)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .start_game(start_game),
        .rand_in(rand_in), .hit_valid(hit_valid), .hit_box(hit_box),
        .target_box(target_box), .target_valid(target_valid),
        .score(score), .time_left(time_left), .level(level),
        .game_over(game_over), .hit_flag(hit_flag), .miss_flag(miss_flag)
`ifdef STREAK_BONUS_EN
        , .streak(streak)
`endif
    );

    game_round_engine #(
        .NUM_BOXES(NB), .BOX_W(3), .SCORE_W(3), .TICKS_PER_SEC(TPS),
        .GAME_SECONDS(GS), .LEVEL_STEP_SEC(STEP), .NUM_LEVELS(NL),
        .WINDOW_TICKS(WT)
    ) dut_s (
        .CLOCK_50(clk), .reset(reset), .start_game(start_game),
        .rand_in(rand_in), .hit_valid(hit_valid), .hit_box(hit_box),
        .target_box(target_box_s), .target_valid(target_valid_s),
        .score(score_s), .time_left(time_left_s), .level(level_s),
        .game_over(game_over_s), .hit_flag(hit_flag_s), .miss_flag(miss_flag_s)
`ifdef STREAK_BONUS_EN
        , .streak(streak_s)
`endif
    );

    int nvec = 0;
    int nbad = 0;

    // Reference model: elapsed active cycles drive time and level
    int m_ph = P_IDLE;
    int m_cyc = 0;
    int m_sc = 0;
    int m_ss = 0;
    int m_tgt = 0;
    int m_win = 0;
    int m_hf = 0;
    int m_mf = 0;

    function automatic int m_lvl();
        int l;
        l = 1 + (m_cyc / TPS) / STEP;
        return (l > NL) ? NL : l;
    endfunction

    function automatic int m_tl();
        return GS - m_cyc / TPS;
    endfunction

    function automatic void model_step(int rst, int st, int rnd, int hv, int hb);
        int lv;
        int t;
        lv = m_lvl();
        m_hf = 0;
        m_mf = 0;
        if (rst != 0) begin
            m_ph = P_IDLE; m_cyc = 0; m_sc = 0; m_ss = 0;
            m_tgt = 0; m_win = 0;
            return;
        end
        case (m_ph)
            P_IDLE: if (st != 0) m_ph = P_ARM;
            P_OVER: if (st != 0) begin
                m_ph = P_ARM; m_cyc = 0; m_sc = 0; m_ss = 0;
            end
            P_ARM: begin
                t = rnd;
                if (t >= NB) t = t - NB;
                if (t == m_tgt) t = (t + 1) % NB;
                m_tgt = t;
                m_win = WT >> (lv - 1);
                m_ph = P_WAIT;
                m_cyc++;
            end
            default: begin
                if (hv != 0 && hb == m_tgt) begin
                    m_hf = 1;
                    m_sc = (m_sc + lv > SMAX) ? SMAX : m_sc + lv;
                    m_ss = (m_ss + lv > SMAX_S) ? SMAX_S : m_ss + lv;
                    m_ph = P_ARM;
                end else if (hv != 0 || m_win <= 1) begin
                    m_mf = 1;
                    m_sc = (m_sc > 0) ? m_sc - 1 : 0;
                    m_ss = (m_ss > 0) ? m_ss - 1 : 0;
                    m_ph = P_ARM;
                end else begin
                    m_win--;
                end
                m_cyc++;
            end
        endcase
        if ((m_ph == P_ARM || m_ph == P_WAIT) && m_cyc == GS * TPS)
            m_ph = P_OVER;
    endfunction

    task automatic drive(int rst, int st, int rnd, int hv, int hb);
        reset      = (rst != 0);
        start_game = (st != 0);
        rand_in    = 3'(rnd);
        hit_valid  = (hv != 0);
        hit_box    = 3'(hb);
        model_step(rst, st, rnd, hv, hb);
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, int etb, int etv, int esc, int ess,
                         int etl, int elv, int ego, int ehf, int emf);
        bit bad;
        nvec++;
        bad = (target_box !== 3'(etb)) || (target_valid !== 1'(etv))
           || (score !== 11'(esc)) || (time_left !== 8'(etl))
           || (level !== 3'(elv)) || (game_over !== 1'(ego))
           || (hit_flag !== 1'(ehf)) || (miss_flag !== 1'(emf))
           || (score_s !== 3'(ess)) || (target_box_s !== 3'(etb))
           || (target_valid_s !== 1'(etv)) || (time_left_s !== 8'(etl))
           || (level_s !== 3'(elv)) || (game_over_s !== 1'(ego))
           || (hit_flag_s !== 1'(ehf)) || (miss_flag_s !== 1'(emf));
        if (bad) begin
            nbad++;
            $display("FAIL %s: got tb=%0d tv=%0d sc=%0d ss=%0d tl=%0d lv=%0d go=%0d hf=%0d mf=%0d | want tb=%0d tv=%0d sc=%0d ss=%0d tl=%0d lv=%0d go=%0d hf=%0d mf=%0d",
                nm, target_box, target_valid, score, score_s, time_left,
                level, game_over, hit_flag, miss_flag,
                etb, etv, esc, ess, etl, elv, ego, ehf, emf);
        end
    endtask

    typedef struct {
        int rst, st, rnd, hv, hb;
        int tb, tv, sc, ss, tl, lv, go, hf, mf;
    } vec_t;

    vec_t tbl[30];

    initial begin
        tbl[0]  = '{1,0,0,0,0, 0,0,0,0,6,1,0,0,0};
        tbl[1]  = '{0,1,0,0,0, 0,0,0,0,6,1,0,0,0};
        tbl[2]  = '{0,0,2,0,0, 2,1,0,0,6,1,0,0,0};
        tbl[3]  = '{0,0,0,1,2, 2,0,1,1,6,1,0,1,0};
        tbl[4]  = '{0,0,2,0,0, 3,1,1,1,6,1,0,0,0};
        tbl[5]  = '{0,0,0,1,4, 3,0,0,0,5,1,0,0,1};
        tbl[6]  = '{0,0,7,0,0, 1,1,0,0,5,1,0,0,0};
        tbl[7]  = '{0,0,0,1,4, 1,0,0,0,5,1,0,0,1};
        tbl[8]  = '{0,0,0,0,0, 0,1,0,0,5,1,0,0,0};
        tbl[9]  = '{0,0,0,1,0, 0,0,1,1,4,2,0,1,0};
        tbl[10] = '{0,0,5,0,0, 5,1,1,1,4,2,0,0,0};
        tbl[11] = '{0,0,0,0,0, 5,1,1,1,4,2,0,0,0};
        tbl[12] = '{0,0,0,0,0, 5,1,1,1,4,2,0,0,0};
        tbl[13] = '{0,0,0,0,0, 5,1,1,1,3,2,0,0,0};
        tbl[14] = '{0,0,0,0,0, 5,0,0,0,3,2,0,0,1};
        tbl[15] = '{0,0,3,0,0, 3,1,0,0,3,2,0,0,0};
        tbl[16] = '{0,1,0,0,0, 3,1,0,0,3,2,0,0,0};
        tbl[17] = '{0,0,0,0,0, 3,1,0,0,2,3,0,0,0};
        tbl[18] = '{0,0,0,0,0, 3,1,0,0,2,3,0,0,0};
        tbl[19] = '{0,0,0,1,3, 3,0,3,3,2,3,0,1,0};
        tbl[20] = '{0,0,3,1,3, 4,1,3,3,2,3,0,0,0};
        tbl[21] = '{0,0,0,0,0, 4,1,3,3,1,3,0,0,0};
        tbl[22] = '{0,0,0,1,4, 4,0,6,6,1,3,0,1,0};
        tbl[23] = '{0,0,1,0,0, 1,1,6,6,1,3,0,0,0};
        tbl[24] = '{0,0,0,0,0, 1,1,6,6,1,3,0,0,0};
        tbl[25] = '{0,0,0,1,1, 1,0,9,7,0,3,1,1,0};
        tbl[26] = '{0,1,0,0,0, 1,0,0,0,6,1,0,0,0};
        tbl[27] = '{0,0,4,0,0, 4,1,0,0,6,1,0,0,0};
        tbl[28] = '{1,0,0,1,4, 0,0,0,0,6,1,0,0,0};
        tbl[29] = '{0,0,0,0,0, 0,0,0,0,6,1,0,0,0};

        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].rst, tbl[i].st, tbl[i].rnd, tbl[i].hv, tbl[i].hb);
            check($sformatf("tbl%0d", i), tbl[i].tb, tbl[i].tv, tbl[i].sc,
                  tbl[i].ss, tbl[i].tl, tbl[i].lv, tbl[i].go, tbl[i].hf,
                  tbl[i].mf);
        end

        for (int i = 0; i < 2000; i++) begin
            int rst, st, rnd, hv, hb;
            rst = ($urandom_range(0, 299) == 0) ? 1 : 0;
            st  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            rnd = int'($urandom_range(0, 7));
            hv  = ($urandom_range(0, 1) == 0) ? 1 : 0;
            hb  = ($urandom_range(0, 19) < 17) ? m_tgt
                                                : int'($urandom_range(0, 7));
            drive(rst, st, rnd, hv, hb);
            check($sformatf("rnd%0d", i), m_tgt,
                  (m_ph == P_WAIT) ? 1 : 0, m_sc, m_ss, m_tl(), m_lvl(),
                  (m_ph == P_OVER) ? 1 : 0, m_hf, m_mf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
